key_entry_fsm: RTL
==================

# key_entry_fsm

Keypad entry sequencer feeding the ALU operation decoder. It consumes one-cycle key strobes from the debounced keypad scanner and assembles decimal operand A, an operation key, and decimal operand B into binary operands. On '=' it presents `opA`, `opB` and the 4-bit `opKey` to the decoder/ALU with a valid/ack handshake. It also detects entry overflow and supports a global clear.

## Interface
- `W`, 8: operand width in bits (binary, unsigned).
- `MAX_DIGITS`, 3: maximum decimal digits per operand.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `keyCode`  in  4  key code, qualified by `keyValid`.
- `keyValid`  in  1  one-cycle strobe, one key per high cycle.
- `ack`  in  1  consumer accepted the presented operation.
- `opA`  out  W  operand A, binary.
- `opB`  out  W  operand B, binary.
- `opKey`  out  4  operation key: 1100 add, 1101 sub, 1110 mult.
- `outVal`  out  1  `opA`/`opB`/`opKey` valid and stable.
- `err`  out  1  entry overflow, sticky until clear/reset.
- `disp`  out  W  present only with `KEYENTRY_ECHO_EN` (see Configuration).

## Operation
- Key map: 0000–1001 digits 0–9; 1100/1101/1110 op keys; 1111 '='; 1010 clear; 1011 ignored.
- States: `ENTER_A`, `ENTER_B`, `VALID`, `ERR`. Internal: digit counters `cntA`, `cntB`.
- `ENTER_A`: digit → `opA = opA*10 + d`, `cntA++`. Op key with `cntA ≥ 1` → latch `opKey`, go `ENTER_B`. Op key with `cntA = 0` ignored. '=' ignored.
- `ENTER_B`: digit → `opB = opB*10 + d`, `cntB++`. Op key with `cntB = 0` replaces `opKey`. Op key with `cntB ≥ 1` ignored. '=' with `cntB ≥ 1` → `VALID`. '=' with `cntB = 0` ignored.
- Overflow: a digit that would make the count exceed `MAX_DIGITS`, or the product-plus-digit exceed 2^W−1, → `ERR`. The target operand is left unchanged. The check uses a W+4-bit intermediate.
- `VALID`: `outVal = 1`, and all operand/op outputs hold. Digits, op keys and '=' are ignored. `ack` → `ENTER_A` with `opA`, `opB`, `cntA`, `cntB` cleared. `opKey` keeps its last value.
- `ERR`: `err = 1`. Only clear leaves this state.
- Clear (1010) in any state → `ENTER_A`, with `opA`, `opB`, `opKey`, counters, `err` and `outVal` all zeroed.
- `ack` outside `VALID` is ignored.

## Timing
- Reset: `rst_n` low at a rising edge → state `ENTER_A`. `opA = 0`, `opB = 0`, `opKey = 0000`, `outVal = 0`, `err = 0`, `disp = 0`. Reset mid-entry discards all partial data.
- A key sampled at edge n is visible on outputs from edge n (registered). Its effect appears in cycle n+1.
- `outVal` rises the cycle after '=' is sampled. It falls the cycle after `ack` is sampled high with `outVal` high.
- Simultaneous `ack` and clear in `VALID`: clear wins, with the same end result plus `opKey = 0000`.
- `keyValid` held high for k cycles = k key presses. The upstream scanner guarantees single-cycle strobes.
- Zero combinational paths from inputs to outputs.

## Configuration
- `KEYENTRY_ECHO_EN` defined: adds output `disp[W-1:0]`, registered.
  - `ENTER_A` shows `opA`.
  - `ENTER_B` shows `opB`, or `opA` while `cntB = 0`.
  - `VALID` shows `opB`.
  - `ERR` shows 0.
- Not defined: no `disp` port and no echo logic. All other behaviour is identical.

## Test plan
- Reset, then keys 1,2,1100,3,4,1111 → `outVal` high one cycle after '=', `opA = 12`, `opB = 34`, `opKey = 1100`. `ack` → `outVal = 0` next cycle, `opA = opB = 0`.
- Keys 7,1100,1101,1110,5,1111 → `opKey = 1110`, `opA = 7`, `opB = 5`. Then 1101 after digit 5 (before '=') is ignored.
- `W = 8`: keys 2,5,6 → `ERR`, `err = 1`, `opA = 25`. Keys 1,2,3,4 → 4th digit → `ERR`. Clear → `err = 0`, state `ENTER_A`.
- In `VALID`, key 9, '=' and op keys arrive → no output change. Clear and `ack` in the same cycle → all outputs 0 next cycle.
- `rst_n` low after keys 4,1100,2 → all outputs 0. Keys 1,1101,1,1111 → `opA = 1`, `opB = 1`, `opKey = 1101`.
- With `KEYENTRY_ECHO_EN`: keys 4,2 → `disp = 42`. Key 1100 → `disp = 42`. Key 9 → `disp = 9`.

Source files
------------

// File: rtl/key_entry_fsm.sv
// Keypad entry sequencer: builds decimal operands A and B plus an op key, then hands them over on '='.
// Define KEYENTRY_ECHO_EN to add the registered display echo output disp.
module key_entry_fsm #(
    parameter int W          = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   keyCode,
    input  logic         keyValid,
    input  logic         ack,
    output logic [W-1:0] opA,
    output logic [W-1:0] opB,
    output logic [3:0]   opKey,
    output logic         outVal,
    output logic         err
`ifdef KEYENTRY_ECHO_EN
    ,
    output logic [W-1:0] disp
`endif
);

    localparam int            CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

    // ENTER_A/ENTER_B collect operands, VALID holds the handshake, ERR latches overflow
    typedef enum logic [1:0] {ENTER_A, ENTER_B, VALID, ERR} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  opa_nx, opb_nx;
    logic [3:0]    opkey_nx;
    logic [CW-1:0] cnt_a, cnt_b, cnt_a_nx, cnt_b_nx;
    logic          is_digit, is_op, is_eq, is_clr;
    logic [W-1:0]  operand;
    logic [W+3:0]  acc;
    logic          acc_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ENTER_A;
            opA   <= '0;
            opB   <= '0;
            opKey <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            state <= state_nx;
            opA   <= opa_nx;
            opB   <= opb_nx;
            opKey <= opkey_nx;
            cnt_a <= cnt_a_nx;
            cnt_b <= cnt_b_nx;
        end
    end

    always_comb begin
        is_digit = keyValid && (keyCode <= 4'd9);
        is_op    = keyValid && (keyCode >= 4'hC) && (keyCode <= 4'hE);
        is_eq    = keyValid && (keyCode == 4'hF);
        is_clr   = keyValid && (keyCode == 4'hA);
        operand  = (state == ENTER_B) ? opB : opA;
        // W+4 bits always holds (2^W-1)*10+9, so the upper nibble flags overflow
        acc      = ((W+4)'(operand) * (W+4)'(10)) + (W+4)'(keyCode);
        acc_ovf  = |acc[W+3:W];
    end

    always_comb begin
        state_nx = state;
        opa_nx   = opA;
        opb_nx   = opB;
        opkey_nx = opKey;
        cnt_a_nx = cnt_a;
        cnt_b_nx = cnt_b;
        case (state)
            ENTER_A: begin
                if (is_digit) begin
                    if (cnt_a == CNT_MAX || acc_ovf) begin
                        state_nx = ERR;
                    end else begin
                        opa_nx   = acc[W-1:0];
                        cnt_a_nx = cnt_a + CW'(1);
                    end
                end else if (is_op && cnt_a != '0) begin
                    opkey_nx = keyCode;
                    state_nx = ENTER_B;
                end
            end
            ENTER_B: begin
                if (is_digit) begin
                    if (cnt_b == CNT_MAX || acc_ovf) begin
                        state_nx = ERR;
                    end else begin
                        opb_nx   = acc[W-1:0];
                        cnt_b_nx = cnt_b + CW'(1);
                    end
                end else if (is_op && cnt_b == '0) begin
                    opkey_nx = keyCode;
                end else if (is_eq && cnt_b != '0) begin
                    state_nx = VALID;
                end
            end
            VALID: begin
                if (ack) begin
                    state_nx = ENTER_A;
                    opa_nx   = '0;
                    opb_nx   = '0;
                    cnt_a_nx = '0;
                    cnt_b_nx = '0;
                end
            end
            default: ;
        endcase
        // clear overrides everything, including a coincident ack
        if (is_clr) begin
            state_nx = ENTER_A;
            opa_nx   = '0;
            opb_nx   = '0;
            opkey_nx = '0;
            cnt_a_nx = '0;
            cnt_b_nx = '0;
        end
    end

    always_comb begin
        outVal = (state == VALID);
        err    = (state == ERR);
    end

`ifdef KEYENTRY_ECHO_EN
    logic [W-1:0] disp_nx;

    always_comb begin
        disp_nx = '0;
        case (state_nx)
            ENTER_A: disp_nx = opa_nx;
            ENTER_B: disp_nx = (cnt_b_nx == '0) ? opa_nx : opb_nx;
            VALID:   disp_nx = opb_nx;
            default: disp_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) disp <= '0;
        else        disp <= disp_nx;
    end
`endif

endmodule
